// File: rtl/lemming_world.sv
// lemming_world: terrain bitmap and lemming position model driving the lemming walker FSM.
module lemming_world #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int DIG_CYCLES = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(DEPTH),
    localparam int CW = DIG_CYCLES > 1 ? $clog2(DIG_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          run,
    input  logic          load_en,
    input  logic [YW-1:0] load_row,
    input  logic [WIDTH-1:0] load_data,
    input  logic          restart,
    input  logic [XW-1:0] init_x,
    input  logic [YW-1:0] init_y,
    input  logic          dig_cmd,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    output logic          ground,
    output logic          bump_left,
    output logic          bump_right,
    output logic          dig,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [7:0]    fall_rows,
    output logic          proto_err
);
    logic [DEPTH-1:0][WIDTH-1:0] map;
    logic [CW-1:0] dig_cnt;
    logic dig_pending;
    logic [YW-1:0] y_dn;
    logic floor_row;
    logic multi;
    logic [3:0] w;

    assign w         = {walk_left, walk_right, aaah, digging};
    assign multi     = $countones(w) > 1;
    assign y_dn      = pos_y + 1'b1;
    assign floor_row = pos_y == YW'(DEPTH - 1);
    // Edge terms short-circuit the wrapped neighbour index so it is never meaningful at a boundary.
    assign ground     = floor_row | map[y_dn][pos_x];
    assign bump_left  = (pos_x == '0) | map[pos_y][pos_x - 1'b1];
    assign bump_right = (pos_x == XW'(WIDTH - 1)) | map[pos_y][pos_x + 1'b1];
    assign dig        = dig_pending;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            map         <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            fall_rows   <= '0;
            dig_cnt     <= '0;
            dig_pending <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (!run && load_en)
                map[load_row] <= load_data;
            if (dig_cmd)
                dig_pending <= 1'b1;
            else if (restart || (run && (digging || aaah)))
                dig_pending <= 1'b0;
            if (run && multi)
                proto_err <= 1'b1;
            if (restart) begin
                pos_x     <= init_x;
                pos_y     <= init_y;
                fall_rows <= '0;
                dig_cnt   <= '0;
            end else if (run) begin
                dig_cnt   <= '0;
                fall_rows <= '0;
                case (w)
                    4'b1000: if (!bump_left) pos_x <= pos_x - 1'b1;
                    4'b0100: if (!bump_right) pos_x <= pos_x + 1'b1;
                    4'b0010: begin
                        fall_rows <= fall_rows;
                        if (!ground) begin
                            pos_y     <= y_dn;
                            fall_rows <= fall_rows + {7'd0, fall_rows != 8'hFF};
                        end
                    end
                    4'b0001: if (ground && !floor_row) begin
                        if (dig_cnt == CW'(DIG_CYCLES - 1))
                            map[y_dn][pos_x] <= 1'b0;
                        else
                            dig_cnt <= dig_cnt + 1'b1;
                    end
                    4'b0000: begin
                        dig_cnt   <= dig_cnt;
                        fall_rows <= fall_rows;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lemming_world.sv
// tb_lemming_world: directed checks of movement, falling, digging, loads and protocol errors.
module tb_lemming_world;
    logic clk = 1'b0, areset_n = 1'b0, run = 1'b0, load_en = 1'b0, restart = 1'b0, dig_cmd = 1'b0;
    logic [2:0] load_row = '0, init_y = '0;
    logic [15:0] load_data = '0;
    logic [3:0] init_x = '0;
    logic walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
    logic ground, bump_left, bump_right, dig, proto_err;
    logic [3:0] pos_x;
    logic [2:0] pos_y;
    logic [7:0] fall_rows;
    int checks = 0, fails = 0;

    lemming_world dut (
        .clk(clk), .areset_n(areset_n), .run(run), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .restart(restart), .init_x(init_x), .init_y(init_y),
        .dig_cmd(dig_cmd), .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
        .digging(digging), .ground(ground), .bump_left(bump_left), .bump_right(bump_right),
        .dig(dig), .pos_x(pos_x), .pos_y(pos_y), .fall_rows(fall_rows), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_restart(input logic [3:0] x, input logic [2:0] y);
        init_x = x; init_y = y; restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        #3 areset_n = 1'b1;
        cyc();
    endtask

    initial begin
        cyc(2);
        chk("rst_x", pos_x, 0); chk("rst_y", pos_y, 0); chk("rst_fall", fall_rows, 0);
        chk("rst_perr", proto_err, 0); chk("rst_dig", dig, 0);
        areset_n = 1'b1;
        cyc();
        chk("rst_ground", ground, 0); chk("rst_bl", bump_left, 1); chk("rst_br", bump_right, 0);
        // floor row start
        do_restart(0, 7);
        chk("t1_x", pos_x, 0); chk("t1_y", pos_y, 7); chk("t1_ground", ground, 1);
        chk("t1_bl", bump_left, 1); chk("t1_br", bump_right, 0); chk("t1_dig", dig, 0);
        // walk right to the right wall
        run = 1'b1; walk_right = 1'b1;
        cyc(14);
        chk("t2_x14", pos_x, 14); chk("t2_br14", bump_right, 0);
        cyc();
        chk("t2_x15", pos_x, 15); chk("t2_br15", bump_right, 1);
        cyc(5);
        chk("t2_hold", pos_x, 15); chk("t2_fall", fall_rows, 0);
        // obstacle at column 5 of the floor row
        run = 1'b0; walk_right = 1'b0;
        load_en = 1'b1; load_row = 3'd7; load_data = 16'h0020;
        cyc();
        load_en = 1'b0;
        do_restart(0, 7);
        run = 1'b1; walk_right = 1'b1;
        cyc(10);
        chk("t3_block_x", pos_x, 4); chk("t3_block_br", bump_right, 1);
        walk_right = 1'b0; walk_left = 1'b1;
        load_en = 1'b1; load_data = 16'h0000;
        cyc();
        load_en = 1'b0;
        cyc(3);
        chk("t3_left_x", pos_x, 0); chk("t3_left_bl", bump_left, 1);
        run = 1'b0; walk_left = 1'b0;
        do_restart(4, 7);
        chk("t3_load_ignored", bump_right, 1);
        // free fall through an empty map
        do_reset();
        do_restart(3, 0);
        chk("t4_ground0", ground, 0);
        run = 1'b1; aaah = 1'b1;
        cyc(3);
        chk("t4_y3", pos_y, 3); chk("t4_fall3", fall_rows, 3);
        cyc(4);
        chk("t4_y7", pos_y, 7); chk("t4_ground7", ground, 1); chk("t4_fall7", fall_rows, 7);
        cyc();
        chk("t4_land_y", pos_y, 7); chk("t4_land_fall", fall_rows, 7);
        aaah = 1'b0; walk_right = 1'b1;
        cyc();
        chk("t4_fall_clr", fall_rows, 0); chk("t4_walk_x", pos_x, 4);
        // dig through row 5
        run = 1'b0; walk_right = 1'b0;
        load_en = 1'b1; load_row = 3'd5; load_data = 16'hFFFF;
        cyc();
        load_en = 1'b0;
        do_restart(2, 4);
        chk("t5_ground", ground, 1);
        dig_cmd = 1'b1;
        cyc();
        dig_cmd = 1'b0;
        chk("t5_dig_set", dig, 1);
        run = 1'b1;
        cyc();
        chk("t5_dig_idle", dig, 1);
        digging = 1'b1;
        cyc();
        chk("t5_dig_clr", dig, 0); chk("t5_g1", ground, 1);
        cyc(2);
        chk("t5_g3", ground, 1);
        cyc();
        chk("t5_hole", ground, 0); chk("t5_x", pos_x, 2); chk("t5_y", pos_y, 4);
        digging = 1'b0; aaah = 1'b1;
        cyc(3);
        chk("t5_fall_y", pos_y, 7); chk("t5_fall_rows", fall_rows, 3); chk("t5_fall_g", ground, 1);
        // protocol error
        aaah = 1'b0; walk_left = 1'b1; walk_right = 1'b1;
        cyc();
        chk("t6_perr", proto_err, 1); chk("t6_x", pos_x, 2); chk("t6_y", pos_y, 7);
        walk_left = 1'b0; walk_right = 1'b0;
        cyc(3);
        chk("t6_sticky", proto_err, 1);
        do_reset();
        chk("t6_reset_clr", proto_err, 0);
        // restart cancels a pending dig
        run = 1'b0;
        dig_cmd = 1'b1;
        cyc();
        dig_cmd = 1'b0;
        chk("t7_dig_set", dig, 1);
        do_restart(1, 1);
        chk("t7_restart_clr", dig, 0); chk("t7_x", pos_x, 1); chk("t7_y", pos_y, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
